// File: rtl/trace_pkg.sv
// Shared definitions for the commit trace buffer: the kind encoding and the
// trace entry layout at the default widths.
package trace_pkg;

   localparam int KIND_W = 3;

   localparam logic [KIND_W-1:0] KIND_NOP   = 3'd0;
   localparam logic [KIND_W-1:0] KIND_REG   = 3'd1;
   localparam logic [KIND_W-1:0] KIND_LOAD  = 3'd2;
   localparam logic [KIND_W-1:0] KIND_STORE = 3'd3;
   localparam logic [KIND_W-1:0] KIND_HALT  = 3'd4;

   localparam int TRACE_DATA_W = 16;
   localparam int TRACE_REG_AW = 4;
   localparam int TRACE_CNT_W  = 32;

   // Field order matches the packing used inside commit_trace_buffer.
   typedef struct packed {
      logic [KIND_W-1:0]       kind;
      logic [TRACE_CNT_W-1:0]  inum;
      logic [TRACE_DATA_W-1:0] pc;
      logic [TRACE_REG_AW-1:0] rd;
      logic [TRACE_DATA_W-1:0] value;
      logic [TRACE_DATA_W-1:0] addr;
   } traceEntry_t;

   // Flat width of one entry for arbitrary data/register/counter widths.
   function automatic int entryWidth(input int dataW, input int regAw, input int cntW);
      return KIND_W + cntW + 3 * dataW + regAw;
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic synchronous first-word-fall-through FIFO. The head entry is read
// combinationally from storage; an empty FIFO presents all-zero data.
// Full/empty use one extra pointer bit so pointers simply wrap modulo DEPTH.
module trace_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wrData,
   input  logic             pop,
   output logic [WIDTH-1:0] rdData,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W:0]   wrPtr;
   logic [PTR_W:0]   rdPtr;
   logic             doPush;
   logic             doPop;

   assign empty  = (wrPtr == rdPtr);
   assign full   = (wrPtr[PTR_W] != rdPtr[PTR_W]) &&
                   (wrPtr[PTR_W-1:0] == rdPtr[PTR_W-1:0]);
   // A push into a full FIFO is legal when the head leaves on the same edge.
   assign doPop  = pop && !empty;
   assign doPush = push && (!full || doPop);
   assign rdData = empty ? '0 : mem[rdPtr[PTR_W-1:0]];

   // Pointer update; reset empties the FIFO.
   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + PTR_ONE;
         if (doPop)  rdPtr <= rdPtr + PTR_ONE;
      end
   end

   // Entry storage write; contents are don't-care until pointed at.
   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr[PTR_W-1:0]] <= wrData;
   end

endmodule

// File: rtl/commit_trace_buffer.sv
// Retire-event tracer: classifies each commit, tags it with an instruction
// number and queues it in a FWFT FIFO drained over a valid/ready stream.
// Also tracks cycle/instruction counts, halt, overflow/drop and timeout.
// Optional build macro TRACE_FILTER_NOP_EN: NOP-kind commits consume an inum
// but are never queued (and never count as drops).
module commit_trace_buffer
   import trace_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int REG_AW      = 4,
   parameter int DEPTH       = 16,
   parameter int CNT_W       = 32,
   parameter int CYCLE_LIMIT = 100000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cm_valid,
   input  logic [DATA_W-1:0] cm_pc,
   input  logic              cm_regwrite,
   input  logic [REG_AW-1:0] cm_reg,
   input  logic [DATA_W-1:0] cm_wdata,
   input  logic              cm_memread,
   input  logic              cm_memwrite,
   input  logic [DATA_W-1:0] cm_addr,
   input  logic [DATA_W-1:0] cm_mdata,
   input  logic              cm_halt,
   output logic              tr_valid,
   input  logic              tr_ready,
   output logic [KIND_W-1:0] tr_kind,
   output logic [CNT_W-1:0]  tr_inum,
   output logic [DATA_W-1:0] tr_pc,
   output logic [REG_AW-1:0] tr_reg,
   output logic [DATA_W-1:0] tr_value,
   output logic [DATA_W-1:0] tr_addr,
   output logic [CNT_W-1:0]  inst_count,
   output logic [CNT_W-1:0]  cycle_count,
   output logic              halted,
   output logic              overflow,
   output logic [CNT_W-1:0]  drop_count,
   output logic              timeout
);

   localparam int               ENTRY_W = entryWidth(DATA_W, REG_AW, CNT_W);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(CYCLE_LIMIT);

   logic [KIND_W-1:0]  cmKind;
   logic [REG_AW-1:0]  entryReg;
   logic [DATA_W-1:0]  entryValue;
   logic [DATA_W-1:0]  entryAddr;
   logic               accept;
   logic               keep;
   logic               fifoPush;
   logic               fifoPop;
   logic               fifoFull;
   logic               fifoEmpty;
   logic               drop;
   logic [CNT_W-1:0]   cycleNext;
   logic [ENTRY_W-1:0] wrEntry;
   logic [ENTRY_W-1:0] rdEntry;

   // Classify the retiring instruction and zero the fields its kind does not use.
   always_comb begin
      cmKind     = KIND_NOP;
      entryReg   = '0;
      entryValue = '0;
      entryAddr  = '0;
      if (cm_regwrite && cm_memread) begin
         cmKind     = KIND_LOAD;
         entryReg   = cm_reg;
         entryValue = cm_wdata;
         entryAddr  = cm_addr;
      end else if (cm_regwrite) begin
         cmKind     = KIND_REG;
         entryReg   = cm_reg;
         entryValue = cm_wdata;
      end else if (cm_halt) begin
         cmKind     = KIND_HALT;
      end else if (cm_memwrite) begin
         cmKind     = KIND_STORE;
         entryValue = cm_mdata;
         entryAddr  = cm_addr;
      end
   end

   assign accept = cm_valid && !halted;

`ifdef TRACE_FILTER_NOP_EN
   assign keep = accept && (cmKind != KIND_NOP);
`else
   assign keep = accept;
`endif

   assign tr_valid  = !fifoEmpty;
   assign fifoPop   = tr_valid && tr_ready;
   assign fifoPush  = keep && (!fifoFull || fifoPop);
   assign drop      = keep && fifoFull && !fifoPop;
   assign cycleNext = (cycle_count == CNT_MAX) ? cycle_count : cycle_count + CNT_ONE;
   assign wrEntry   = {cmKind, inst_count, cm_pc, entryReg, entryValue, entryAddr};

   assign {tr_kind, tr_inum, tr_pc, tr_reg, tr_value, tr_addr} = rdEntry;

   trace_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .push   (fifoPush),
      .wrData (wrEntry),
      .pop    (fifoPop),
      .rdData (rdEntry),
      .full   (fifoFull),
      .empty  (fifoEmpty)
   );

   // Free-running saturating cycle counter and sticky timeout.
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_count <= '0;
         timeout     <= 1'b0;
      end else begin
         cycle_count <= cycleNext;
         if (CYCLE_LIMIT != 0 && cycleNext == LIMIT) timeout <= 1'b1;
      end
   end

   // Instruction numbering and sticky halt; every accepted commit takes an inum.
   always_ff @(posedge clk) begin
      if (rst) begin
         inst_count <= '0;
         halted     <= 1'b0;
      end else if (accept) begin
         inst_count <= inst_count + CNT_ONE;
         if (cmKind == KIND_HALT) halted <= 1'b1;
      end
   end

   // Overflow flag and saturating drop counter for commits that found no room.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (drop_count != CNT_MAX) drop_count <= drop_count + CNT_ONE;
      end
   end

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Synthesizable retire-event tracer: captures per-commit register, load, store, NOP and halt events from the CPU core into a FIFO, tagged with an instruction number (INUM).
- Drains entries over a valid/ready stream to a host, log dumper or on-chip checker.
- Keeps cycle and instruction counters, halt status, overflow and timeout status, so trace capture works in hardware and in non-simulator flows.
- Generalises the simulation trace logger to arbitrary data and register widths, FIFO depth and counter width.

Parameters:
DATA_W, 16, width of PC, register data, memory address and memory data
REG_AW, 4, register index width
DEPTH, 16, FIFO entries; power of two, minimum 2
CNT_W, 32, width of inum, cycle and drop counters
CYCLE_LIMIT, 100000, cycle count at which timeout asserts; 0 disables

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
cm_valid  in  1  one instruction retires this cycle
cm_pc  in  DATA_W  PC of the retiring instruction
cm_regwrite  in  1  retiring instruction writes the register file
cm_reg  in  REG_AW  destination register
cm_wdata  in  DATA_W  register write data
cm_memread  in  1  retiring instruction is a load
cm_memwrite  in  1  retiring instruction is a store
cm_addr  in  DATA_W  memory address
cm_mdata  in  DATA_W  store data
cm_halt  in  1  retiring instruction is HLT
tr_valid  out  1  FIFO head entry is valid
tr_ready  in  1  consumer accepts the head entry
tr_kind  out  3  0=NOP/branch, 1=REG, 2=LOAD, 3=STORE, 4=HALT
tr_inum  out  CNT_W  instruction number of the entry
tr_pc  out  DATA_W  entry PC
tr_reg  out  REG_AW  entry destination register
tr_value  out  DATA_W  register write value, or store data
tr_addr  out  DATA_W  load/store address
inst_count  out  CNT_W  commits observed
cycle_count  out  CNT_W  cycles since reset
halted  out  1  sticky; HALT commit observed
overflow  out  1  sticky; at least one entry dropped
drop_count  out  CNT_W  number of dropped entries
timeout  out  1  sticky; cycle_count reached CYCLE_LIMIT

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst, sampled at the rising edge of clk.
- Reset effect: every output is 0, the FIFO is empty and all counters are 0. Reset asserted mid-operation discards all FIFO contents on the next edge.
- cycle_count: increments every non-reset cycle and saturates at all-ones.
  - timeout sets on the edge where cycle_count becomes CYCLE_LIMIT.
- Kind classification, in priority order:
  - cm_regwrite && cm_memread → LOAD
  - cm_regwrite → REG
  - cm_halt → HALT
  - cm_memwrite → STORE
  - otherwise NOP
- Entry field contents:
  - REG/LOAD: tr_value = cm_wdata.
  - STORE: tr_value = cm_mdata.
  - tr_addr holds cm_addr for LOAD/STORE and 0 otherwise.
  - Unused fields are 0.
- Commit accept condition: cm_valid && !halted.
  - An accepted commit is assigned tr_inum = inst_count, then inst_count increments, including when the entry is dropped.
  - A gap in tr_inum therefore identifies dropped entries.
- Halt: when a HALT entry is accepted, halted sets on the same edge. All later cm_valid are ignored until rst, and the FIFO continues to drain.
- Push and pop: push happens when a commit is accepted and (!full || pop). Pop is tr_valid && tr_ready.
  - Push and pop in the same cycle are allowed when full; the count is unchanged.
  - Pop and push in the same cycle when empty: there is no bypass, so the entry appears next cycle.
- Drop: an accepted commit that cannot be pushed is not stored; overflow sets and drop_count increments (saturating).
- Latency: an entry pushed at edge N is visible on the tr_* outputs after edge N (first-word-fall-through registered FIFO).
- Empty FIFO: tr_valid=0 and all tr_* data outputs are 0.
- Pointers: wrap modulo DEPTH. Full/empty are resolved with an extra pointer bit.
- Stream rule: tr_* data remains stable while tr_valid && !tr_ready.

Optional Feature:
- Macro: TRACE_FILTER_NOP_EN.
- When defined: NOP-kind commits are not pushed, but they still consume an inum and still increment inst_count. Filtered NOPs never count as drops.
- When undefined: NOP entries are pushed like any other kind.

Decomposition:
- Package trace_pkg holds:
  - the kind encoding constants (KIND_NOP…KIND_HALT) and KIND_W=3
  - the trace entry packed struct, parameterised by width via localparams matching the defaults
- Natural sub-module: trace_fifo, a generic synchronous FWFT FIFO (WIDTH, DEPTH) with push/pop/full/empty.
- Classification logic, counters and sticky flags stay in commit_trace_buffer.

Test Plan:
- Reset, then three commits with tr_ready=1: REG r3=0x00AB at PC 0x0000, STORE addr 0x0010 data 0x1234, NOP → kinds 1,3,0 with inums 0,1,2 appear one cycle after each commit; inst_count=3.
- LOAD commit (regwrite=1, memread=1, r5, value 0xBEEF, addr 0x0020) → kind 2, tr_reg=5, tr_value=0xBEEF, tr_addr=0x0020.
- With tr_ready=0, 18 back-to-back commits at DEPTH=16 → 16 stored, overflow=1, drop_count=2. Drain shows inums 0..15. The next commit gets inum 18.
- FIFO full, then push and pop in the same cycle → no drop, count stays 16, the pushed entry appears last.
- HALT commit followed by two more cm_valid → HALT entry stored, halted=1, inst_count frozen, later commits absent. Assert rst mid-drain → tr_valid=0 and all counters 0 on the next edge.
- CYCLE_LIMIT=50 → timeout=0 at cycle 49 and 1 at cycle 50, sticky. Build with TRACE_FILTER_NOP_EN and send REG, NOP, REG → entries with inums 0 and 2 only, drop_count=0.
